// File: rtl/multu_pkg.sv
// Shared definitions for the iterative shift-add multu sequencer:
// FSM state encoding and default geometry.
package multu_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 6;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/multu_sequencer_if.sv
// Control bundle between the pipeline/datapath and the multu sequencer.
// slave: sequencer side; master: pipeline + datapath side.
interface multu_sequencer_if;

    logic start;
    logic abort;
    logic prod_lsb;
    logic rd_hilo;
    logic dp_load;
    logic dp_add_en;
    logic dp_add_sel;
    logic dp_shift_en;
    logic hilo_wr_en;
    logic busy;
    logic done;
    logic stall;

    modport slave (
        input  start, abort, prod_lsb, rd_hilo,
        output dp_load, dp_add_en, dp_add_sel, dp_shift_en,
               hilo_wr_en, busy, done, stall
    );

    modport master (
        output start, abort, prod_lsb, rd_hilo,
        input  dp_load, dp_add_en, dp_add_sel, dp_shift_en,
               hilo_wr_en, busy, done, stall
    );

endinterface

// File: rtl/multu_iter_counter.sv
// Iteration counter for the multu sequencer: clear/increment, saturating,
// with a flag marking the final (WIDTH-1) iteration.
module multu_iter_counter
    import multu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic inc,
    output logic last
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign last = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/multu_sequencer.sv
// Cycle-level control FSM for the iterative shift-add multu datapath.
// Optional build macro: MULTU_SKIP_ZERO_ADD_EN (skip ADD cycles for zero multiplier bits).
module multu_sequencer
    import multu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input logic              clk,
    input logic              reset_n,
    multu_sequencer_if.slave bus
);

`ifdef MULTU_SKIP_ZERO_ADD_EN
    localparam bit SKIP_ZERO = 1'b1;
`else
    localparam bit SKIP_ZERO = 1'b0;
`endif

    state_t state;
    state_t state_nxt;
    state_t iter_nxt;
    logic   last_iter;
    logic   cnt_clr;
    logic   cnt_inc;

    assign cnt_clr = (state == S_LOAD);
    assign cnt_inc = (state == S_SHIFT);

    multu_iter_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .last    (last_iter)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // prod_lsb already presents the next multiplier bit during LOAD and SHIFT,
    // so a zero bit can go straight to another SHIFT.
    always_comb begin
        iter_nxt  = (SKIP_ZERO && !bus.prod_lsb) ? S_SHIFT : S_ADD;
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start && !bus.abort) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = iter_nxt;
            S_ADD:   state_nxt = S_SHIFT;
            S_SHIFT: state_nxt = last_iter ? S_DONE : iter_nxt;
            S_DONE:  state_nxt = (bus.start && !bus.abort) ? S_LOAD : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (bus.abort && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
        end
    end

    always_comb begin
        bus.dp_load     = (state == S_LOAD);
        bus.dp_add_en   = (state == S_ADD);
        bus.dp_add_sel  = (state == S_ADD) && bus.prod_lsb;
        bus.dp_shift_en = (state == S_SHIFT);
        bus.hilo_wr_en  = (state == S_DONE);
        bus.done        = (state == S_DONE);
        bus.busy        = (state != S_IDLE);
        // HI/LO only updates at the end of DONE, so reads stall through it.
        bus.stall       = bus.rd_hilo && (state != S_IDLE);
    end

endmodule

// File: tb/tb_multu_sequencer.sv
// Scoreboard bench for multu_sequencer: behavioural shift-add datapath drives
// prod_lsb; expected products, latencies and pulse counts come from plain arithmetic.
module tb_multu_sequencer;
    import multu_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    multu_sequencer_if bus();

    multu_sequencer #(
        .WIDTH (W),
        .CNT_W (6)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Datapath model: 65-bit product (carry bit on top) and multiplicand.
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic [64:0] prod = '0;
    logic [31:0] mcand = '0;

    assign bus.prod_lsb = bus.dp_load ? b_in[0] : (bus.dp_shift_en ? prod[1] : prod[0]);

    always @(posedge clk) begin
        if (bus.dp_load) begin
            prod  <= {33'b0, b_in};
            mcand <= a_in;
        end else if (bus.dp_add_en) begin
            prod[64:32] <= {1'b0, prod[63:32]} + (bus.dp_add_sel ? {1'b0, mcand} : 33'b0);
        end else if (bus.dp_shift_en) begin
            prod <= prod >> 1;
        end
    end

    typedef struct {
        logic [63:0] p;
        int          due;
        int          adds;
        int          ones;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic int lat(input logic [31:0] b);
`ifdef MULTU_SKIP_ZERO_ADD_EN
        return 2 + W + $countones(b);
`else
        return 2 + 2 * W;
`endif
    endfunction

    function automatic int exp_adds(input logic [31:0] b);
`ifdef MULTU_SKIP_ZERO_ADD_EN
        return $countones(b);
`else
        return W;
`endif
    endfunction

    // Monitor: counts datapath pulses per operation and retires one
    // scoreboard entry on every done pulse.
    int   n_sh = 0;
    int   n_add = 0;
    int   n_sel = 0;
    exp_t e_mon;

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.dp_load) begin
                n_sh = 0; n_add = 0; n_sel = 0;
            end
            if (bus.dp_shift_en) n_sh++;
            if (bus.dp_add_en) begin
                n_add++;
                if (bus.dp_add_sel) n_sel++;
            end
            if (bus.done) begin
                check("hilo_with_done", bus.hilo_wr_en, 1);
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e_mon = sb.pop_front();
                    check("product", prod[63:0], e_mon.p);
                    check("done_edge", edge_n, e_mon.due);
                    check("shift_count", n_sh, W);
                    check("add_count", n_add, e_mon.adds);
                    check("add_sel_count", n_sel, e_mon.ones);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit push);
        exp_t e;
        bus.start = 1'b1;
        a_in = a;
        b_in = b;
        if (push) begin
            e.p    = {32'b0, a} * {32'b0, b};
            e.due  = edge_n + lat(b);
            e.adds = exp_adds(b);
            e.ones = $countones(b);
            sb.push_back(e);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Called in cycle 1 (LOAD) of an operation; returns in cycle L (DONE),
    // or one cycle after an abort / immediately after a reset release.
    task automatic track(input int L, input int mid_start, input int kill_at, input int kill_kind);
        for (int c = 1; c <= L; c++) begin
            check("busy_in_op", bus.busy, 1);
            check("stall_in_op", bus.stall, bus.rd_hilo);
            check("done_timing", bus.done, (c == L));
            check("hilo_timing", bus.hilo_wr_en, (c == L));
            if (c == 1) check("load_first", bus.dp_load, 1);
            if (kill_at == c) begin
                if (kill_kind == 1) begin
                    bus.abort = 1'b1;
                    @(posedge clk); #1;
                    bus.abort = 1'b0;
                    check("abort_busy", bus.busy, 0);
                    check("abort_done", {bus.done, bus.hilo_wr_en}, 0);
                end else begin
                    reset_n = 1'b0;
                    #1;
                    check("async_reset_outputs",
                          {bus.dp_load, bus.dp_add_en, bus.dp_add_sel, bus.dp_shift_en,
                           bus.hilo_wr_en, bus.busy, bus.done, bus.stall}, 0);
                    @(posedge clk); #1;
                    reset_n = 1'b1;
                end
                return;
            end
            if (mid_start == c) bus.start = 1'b1;
            if (c < L) begin
                @(posedge clk); #1;
                bus.start = 1'b0;
            end
        end
    endtask

    task automatic idle_after();
        @(posedge clk); #1;
        check("idle_busy", bus.busy, 0);
        check("idle_stall", bus.stall, 0);
        check("idle_done", bus.done, 0);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b);
        issue(a, b, 1'b1);
        track(lat(b), 0, 0, 0);
        idle_after();
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.rd_hilo = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {bus.dp_load, bus.dp_add_en, bus.dp_add_sel, bus.dp_shift_en,
               bus.hilo_wr_en, bus.busy, bus.done, bus.stall}, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // rd_hilo in IDLE does not stall; held through an op it stalls until DONE ends.
        check("stall_idle", bus.stall, 0);
        run_op(32'h0000_1234, 32'hFFFF_FFFF);
        bus.rd_hilo = 1'b0;

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(32'h0000_0007, 32'h0000_0005);
        run_op(32'hDEAD_BEEF, 32'h0000_0000);
        run_op(32'hFFFF_FFFF, 32'h8000_0000);

        // Abort in cycle 10, restart in cycle 12.
        issue(32'h1111_1111, 32'h0F0F_0F0F, 1'b0);
        track(lat(32'h0F0F_0F0F), 0, 10, 1);
        @(posedge clk); #1;
        run_op(32'h0000_0003, 32'hF0F0_F0F1);

        // Start while busy is ignored; start during DONE chains the next op.
        issue(32'h1234_5678, 32'hFFFF_FFFE, 1'b1);
        track(lat(32'hFFFF_FFFE), 30, 0, 0);
        issue(32'h8765_4321, 32'h0000_00FF, 1'b1);
        track(lat(32'h0000_00FF), 0, 0, 0);
        idle_after();

        // start together with abort: stays idle; in DONE it still completes then idles.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("start_abort_idle", bus.busy, 0);
        issue(32'h0000_0101, 32'h0000_0011, 1'b1);
        track(lat(32'h0000_0011), 0, 0, 0);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("done_abort_busy", bus.busy, 0);
        check("done_abort_load", bus.dp_load, 0);

        // Reset mid-operation in cycle 20, then a normal operation.
        bus.rd_hilo = 1'b1;
        issue(32'hCAFE_F00D, 32'hFFFF_FFFF, 1'b0);
        track(lat(32'hFFFF_FFFF), 0, 20, 2);
        bus.rd_hilo = 1'b0;
        check("post_reset_idle", bus.busy, 0);
        run_op(32'h0000_0009, 32'h0000_000B);

        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = (i % 4 == 0) ? 32'h0 : $urandom;
            bus.rd_hilo = $urandom_range(0, 1);
            run_op(ra, rb);
        end
        bus.rd_hilo = 1'b0;

        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        checks++;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
